// File: rtl/st7735s_init_sequencer.sv
// ST7735S init sequencer.
// Replays a 9-bit command ROM (D/C + byte) into a byte-wide SPI serializer.
// After SWRESET and SLPOUT it inserts the delays the panel needs. Once the
// table ends, it streams 18-bit pixels as three bytes each and issues a fresh
// RAMWR after every completed frame.
module st7735s_init_sequencer #(
  parameter int SWRESET_DLY = 15000000,
  parameter int SLPOUT_DLY  = 12000000,
  parameter int WIDTH       = 160,
  parameter int HEIGHT      = 120,
  parameter int ROM_LAT     = 3
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        start,
  output logic        rom_resend,
  output logic        rom_advance,
  input  logic [8:0]  rom_command,
  input  logic        rom_finished,
  output logic        spi_valid,
  input  logic        spi_ready,
  output logic [7:0]  spi_data,
  output logic        spi_dc,
  input  logic        pix_valid,
  output logic        pix_ready,
  input  logic [17:0] pix_data,
  output logic        init_done,
  output logic        frame_done,
  output logic        busy
);

  localparam int NPIX  = WIDTH * HEIGHT;
  localparam int PIX_W = (NPIX > 1) ? $clog2(NPIX) : 1;
  localparam logic [PIX_W-1:0] PIX_LAST    = PIX_W'(NPIX - 1);
  localparam logic [23:0]      SETTLE_LAST = 24'((ROM_LAT > 0) ? ROM_LAT - 1 : 0);
  localparam logic [23:0]      SWRESET_CNT = 24'(SWRESET_DLY);
  localparam logic [23:0]      SLPOUT_CNT  = 24'(SLPOUT_DLY);
  localparam logic [8:0]       CMD_SWRESET = 9'h001;
  localparam logic [8:0]       CMD_SLPOUT  = 9'h011;
  localparam logic [7:0]       CMD_RAMWR   = 8'h2C;

  typedef enum logic [3:0] {
    IDLE, REWIND, SETTLE, FETCH, SEND, DELAY, STEP, PIX_WAIT, PIX_SEND, RAMWR
  } state_t;

  state_t            state_q, state_d;
  logic [23:0]       cnt_q, cnt_d;     // shared by ROM settle and post-command delay
  logic [8:0]        cmd_q, cmd_d;     // latched ROM word being sent
  logic [17:0]       pix_q, pix_d;     // latched pixel being sent
  logic [1:0]        sub_q, sub_d;     // byte index within the pixel (R, G, B)
  logic [PIX_W-1:0]  pcnt_q, pcnt_d;   // pixel position within the frame
  logic              init_q, init_d;

  // State and datapath registers; reset clears everything asynchronously.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= IDLE;
      cnt_q   <= '0;
      cmd_q   <= '0;
      pix_q   <= '0;
      sub_q   <= '0;
      pcnt_q  <= '0;
      init_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      cmd_q   <= cmd_d;
      pix_q   <= pix_d;
      sub_q   <= sub_d;
      pcnt_q  <= pcnt_d;
      init_q  <= init_d;
    end
  end

  // Next-state logic and outputs. Outputs are decoded from the registered
  // state, so an asynchronous reset forces them all low at once.
  always_comb begin
    state_d     = state_q;
    cnt_d       = cnt_q;
    cmd_d       = cmd_q;
    pix_d       = pix_q;
    sub_d       = sub_q;
    pcnt_d      = pcnt_q;
    init_d      = init_q;
    rom_resend  = 1'b0;
    rom_advance = 1'b0;
    spi_valid   = 1'b0;
    spi_data    = 8'h00;
    spi_dc      = 1'b0;
    pix_ready   = 1'b0;
    frame_done  = 1'b0;
    init_done   = init_q;
    busy        = (state_q != IDLE);

    case (state_q)
      IDLE: begin
        if (start) state_d = REWIND;
      end

      REWIND: begin
        rom_resend = 1'b1;
        cnt_d      = '0;
        state_d    = SETTLE;
      end

      // Give the ROM its read latency before sampling its output.
      SETTLE: begin
        if (cnt_q >= SETTLE_LAST) state_d = FETCH;
        else                      cnt_d   = cnt_q + 24'd1;
      end

      FETCH: begin
        if (rom_finished) begin
          init_d  = 1'b1;
          state_d = PIX_WAIT;
        end else begin
          cmd_d   = rom_command;
          state_d = SEND;
        end
      end

      SEND: begin
        spi_valid = 1'b1;
        spi_data  = cmd_q[7:0];
        spi_dc    = cmd_q[8];
        if (spi_ready) begin
          if (cmd_q == CMD_SWRESET) begin
            cnt_d   = SWRESET_CNT;
            state_d = DELAY;
          end else if (cmd_q == CMD_SLPOUT) begin
            cnt_d   = SLPOUT_CNT;
            state_d = DELAY;
          end else begin
            state_d = STEP;
          end
        end
      end

      // Counts down the loaded delay; lasts max(delay, 1) cycles.
      DELAY: begin
        if (cnt_q <= 24'd1) state_d = STEP;
        else                cnt_d   = cnt_q - 24'd1;
      end

      STEP: begin
        rom_advance = 1'b1;
        cnt_d       = '0;
        state_d     = SETTLE;
      end

      PIX_WAIT: begin
        pix_ready = 1'b1;
        if (pix_valid) begin
          pix_d   = pix_data;
          sub_d   = 2'd0;
          state_d = PIX_SEND;
        end
      end

      // Each 6-bit channel is left-justified in its byte.
      PIX_SEND: begin
        spi_valid = 1'b1;
        spi_dc    = 1'b1;
        case (sub_q)
          2'd0:    spi_data = {pix_q[17:12], 2'b00};
          2'd1:    spi_data = {pix_q[11:6], 2'b00};
          default: spi_data = {pix_q[5:0], 2'b00};
        endcase
        if (spi_ready) begin
          if (sub_q == 2'd2) begin
            sub_d = 2'd0;
            if (pcnt_q == PIX_LAST) begin
              pcnt_d     = '0;
              frame_done = 1'b1;
              state_d    = RAMWR;
            end else begin
              pcnt_d  = pcnt_q + PIX_W'(1);
              state_d = PIX_WAIT;
            end
          end else begin
            sub_d = sub_q + 2'd1;
          end
        end
      end

      // Re-arm the panel's write pointer for the next frame.
      RAMWR: begin
        spi_valid = 1'b1;
        spi_data  = CMD_RAMWR;
        spi_dc    = 1'b0;
        if (spi_ready) state_d = PIX_WAIT;
      end

      default: state_d = IDLE;
    endcase
  end

endmodule

// File: tb/tb_st7735s_init_sequencer.sv
// Directed bench for st7735s_init_sequencer: ROM model, SPI byte monitor,
// protocol checkers and a linear sequence of directed steps.
module tb_st7735s_init_sequencer;

  localparam int ROM_LAT = 3;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic        start = 1'b0;
  logic        spi_ready = 1'b1;
  logic        pix_valid = 1'b0;
  logic [17:0] pix_data = 18'h0;
  logic        rom_resend, rom_advance, rom_finished;
  logic [8:0]  rom_command;
  logic        spi_valid, spi_dc, pix_ready, init_done, frame_done, busy;
  logic [7:0]  spi_data;
  logic [15:0] outs;

  int total = 0;
  int bad = 0;

  always #5 clk = ~clk;

  st7735s_init_sequencer #(
    .SWRESET_DLY(10), .SLPOUT_DLY(8), .WIDTH(2), .HEIGHT(2), .ROM_LAT(ROM_LAT)
  ) dut (
    .clk(clk), .rst_n(rst_n), .start(start),
    .rom_resend(rom_resend), .rom_advance(rom_advance),
    .rom_command(rom_command), .rom_finished(rom_finished),
    .spi_valid(spi_valid), .spi_ready(spi_ready), .spi_data(spi_data), .spi_dc(spi_dc),
    .pix_valid(pix_valid), .pix_ready(pix_ready), .pix_data(pix_data),
    .init_done(init_done), .frame_done(frame_done), .busy(busy)
  );

  assign outs = {busy, spi_valid, spi_dc, spi_data, pix_ready, init_done,
                 frame_done, rom_resend, rom_advance};

  // Command ROM model: address update on the pulse edge plus two output
  // registers gives three cycles from pulse to valid word.
  logic [8:0] rom_tbl [0:5] = '{9'h001, 9'h011, 9'h0B1, 9'h100, 9'h02C, 9'h000};
  int rom_addr = 0;
  int rom_p1 = 0;
  int rom_p2 = 0;
  always @(posedge clk) begin
    if (rom_resend)                       rom_addr <= 0;
    else if (rom_advance && rom_addr < 5) rom_addr <= rom_addr + 1;
    rom_p1 <= rom_addr;
    rom_p2 <= rom_p1;
  end
  assign rom_command  = rom_tbl[rom_p2];
  assign rom_finished = (rom_command == 9'h000);

  // Byte monitor and protocol checkers.
  int cyc = 0;
  logic [8:0] xb[$];
  int xs[$];
  int resend_cnt = 0, frame_cnt = 0, frame_cyc = -1;
  int adv_viol = 0, res_viol = 0, stab_viol = 0, pr_viol = 0;
  int last_adv = -100;
  logic prev_res = 1'b0, prev_v = 1'b0, prev_r = 1'b0;
  logic [8:0] prev_b = 9'h0;
  always @(posedge clk) begin
    cyc <= cyc + 1;
    if (spi_valid && spi_ready) begin
      xb.push_back({spi_dc, spi_data});
      xs.push_back(cyc);
    end
    if (rom_resend) resend_cnt <= resend_cnt + 1;
    if (frame_done) begin
      frame_cnt <= frame_cnt + 1;
      frame_cyc <= cyc;
    end
    if (rom_advance) begin
      if ((cyc - last_adv) < ROM_LAT + 2) adv_viol <= adv_viol + 1;
      last_adv <= cyc;
    end
    if (rom_resend && prev_res) res_viol <= res_viol + 1;
    if (rst_n && prev_v && !prev_r && (!spi_valid || {spi_dc, spi_data} != prev_b))
      stab_viol <= stab_viol + 1;
    if (pix_ready && spi_valid) pr_viol <= pr_viol + 1;
    prev_res <= rom_resend;
    prev_v   <= spi_valid;
    prev_r   <= spi_ready;
    prev_b   <= {spi_dc, spi_data};
  end

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic wait_xfers(input int target, input int limit, input string tag);
    int n = 0;
    while (xb.size() < target && n < limit) begin
      @(negedge clk);
      n++;
    end
    check(tag, xb.size(), target);
  endtask

  task automatic pulse_start();
    start = 1'b1;
    @(negedge clk);
    start = 1'b0;
  endtask

  task automatic send_pix(input logic [17:0] d, input int gap);
    int n = 0;
    repeat (gap) @(negedge clk);
    pix_data  = d;
    pix_valid = 1'b1;
    while (!pix_ready && n < 100) begin
      @(negedge clk);
      n++;
    end
    check("pix_accept_to", pix_ready, 1'b1);
    @(negedge clk);
    pix_valid = 1'b0;
    pix_data  = 18'($urandom);
  endtask

  logic [8:0] exp_init [0:4]  = '{9'h001, 9'h011, 9'h0B1, 9'h100, 9'h02C};
  logic [8:0] exp_pix  [0:12] = '{9'h1FC, 9'h100, 9'h100, 9'h100, 9'h1FC, 9'h100,
                                  9'h100, 9'h100, 9'h1FC, 9'h1FC, 9'h1FC, 9'h1FC, 9'h02C};

  initial begin
    int n;
    int base;
    int rc;

    // Reset state and quiet period after release
    repeat (3) @(negedge clk);
    check("reset_outs", outs, 16'h0);
    rst_n = 1'b1;
    repeat (4) @(negedge clk);
    check("idle_quiet", outs, 16'h0);

    // Start: one-cycle resend pulse
    pulse_start();
    check("resend_high", rom_resend, 1'b1);
    check("busy_high", busy, 1'b1);
    @(negedge clk);
    check("resend_low", rom_resend, 1'b0);

    // SWRESET goes out first; start during the delay is ignored
    wait_xfers(1, 50, "xfer_swreset_to");
    check("byte_swreset", xb[0], 9'h001);
    pulse_start();
    check("start_ignored", resend_cnt, 1);

    // SLPOUT, then stall the serializer on the next byte
    wait_xfers(2, 100, "xfer_slpout_to");
    spi_ready = 1'b0;
    check("byte_slpout", xb[1], 9'h011);
    n = 0;
    while (!spi_valid && n < 100) begin
      @(negedge clk);
      n++;
    end
    check("b1_valid_to", spi_valid, 1'b1);
    for (int i = 0; i < 5; i++) begin
      check("hold_valid", spi_valid, 1'b1);
      check("hold_data", spi_data, 8'hB1);
      check("hold_dc", spi_dc, 1'b0);
      check("hold_no_xfer", xb.size(), 2);
      if (i < 4) @(negedge clk);
    end
    spi_ready = 1'b1;

    // Rest of the table, then init_done
    wait_xfers(5, 200, "init_bytes_to");
    n = 0;
    while (!init_done && n < 50) begin
      @(negedge clk);
      n++;
    end
    check("init_done", init_done, 1'b1);
    check("init_byte_count", xb.size(), 5);
    check("pix_ready_after_init", pix_ready, 1'b1);
    for (int i = 0; i < 5; i++) check("init_byte", xb[i], exp_init[i]);
    check("gap_swreset", (xs[1] - xs[0]) >= 10, 1'b1);
    check("gap_slpout", (xs[2] - xs[1]) >= 8, 1'b1);

    // First frame: four pixels with random gaps
    send_pix(18'h3F000, $urandom_range(0, 3));
    send_pix(18'h00FC0, $urandom_range(0, 3));
    send_pix(18'h0003F, $urandom_range(0, 3));
    send_pix(18'h3FFFF, $urandom_range(0, 3));
    wait_xfers(18, 100, "frame1_to");
    for (int i = 0; i < 13; i++) check("frame1_byte", xb[5 + i], exp_pix[i]);
    check("frame1_done_cnt", frame_cnt, 1);
    check("frame1_done_cycle", frame_cyc, xs[16]);

    // Second frame proves the pixel counter restarted at zero
    send_pix(18'h12345, $urandom_range(0, 3));
    send_pix(18'h00000, $urandom_range(0, 3));
    send_pix(18'h00000, $urandom_range(0, 3));
    wait_xfers(27, 100, "frame2_part_to");
    check("no_early_frame", frame_cnt, 1);
    check("px5_r", xb[18], 9'h148);
    check("px5_g", xb[19], 9'h134);
    check("px5_b", xb[20], 9'h114);
    send_pix(18'h00000, $urandom_range(0, 3));
    wait_xfers(31, 100, "frame2_to");
    check("frame2_done_cnt", frame_cnt, 2);
    check("frame2_ramwr", xb[30], 9'h02C);

    // Asynchronous reset while a pixel byte is stalled
    spi_ready = 1'b0;
    send_pix(18'h3FFFF, 0);
    check("psend_valid", spi_valid, 1'b1);
    #2 rst_n = 1'b0;
    #1 check("rst_mid_pix", outs, 16'h0);
    @(negedge clk);
    rst_n = 1'b1;
    spi_ready = 1'b1;
    repeat (2) @(negedge clk);
    check("post_rst_quiet", outs, 16'h0);

    // Restart replays from address 0 with a fresh resend pulse
    base = xb.size();
    rc = resend_cnt;
    pulse_start();
    wait_xfers(base + 1, 50, "replay_to");
    check("replay_resend", resend_cnt, rc + 1);
    check("replay_first", xb[base], 9'h001);

    // Asynchronous reset in the SWRESET delay
    repeat (4) @(negedge clk);
    #2 rst_n = 1'b0;
    #1 check("rst_mid_delay", outs, 16'h0);
    @(negedge clk);
    rst_n = 1'b1;
    repeat (3) @(negedge clk);
    check("post_rst2_quiet", outs, 16'h0);

    // Full table again after the second reset
    base = xb.size();
    pulse_start();
    n = 0;
    while (!init_done && n < 300) begin
      @(negedge clk);
      n++;
    end
    check("rerun_init_done", init_done, 1'b1);
    check("rerun_count", xb.size() - base, 5);
    check("rerun_first", xb[base], 9'h001);
    check("rerun_third", xb[base + 2], 9'h0B1);

    // Protocol checkers over the whole run
    check("advance_spacing", adv_viol, 0);
    check("resend_single", res_viol, 0);
    check("spi_stable", stab_viol, 0);
    check("pix_ready_excl", pr_viol, 0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

// File: doc/st7735s_init_sequencer.md
ST7735S_INIT_SEQUENCER -- requirements
Module: st7735s_init_sequencer

Interface
REQ-001 SHALL have parameter SWRESET_DLY, default 15000000, cycles waited after SWRESET (0x001) byte accepted.
REQ-002 SHALL have parameter SLPOUT_DLY, default 12000000, cycles waited after SLPOUT (0x011) byte accepted.
REQ-003 SHALL have parameters WIDTH, default 160, and HEIGHT, default 120; pixels per frame = WIDTH*HEIGHT.
REQ-004 SHALL have parameter ROM_LAT, default 3, cycles from rom_advance/rom_resend pulse to valid rom_command.
REQ-005 clk  in  1  sole clock; all state changes on rising edge.
REQ-006 rst_n  in  1  asynchronous, active-low reset.
REQ-007 start  in  1  begin init sequence; sampled only in IDLE.
REQ-008 rom_resend  out  1  one-cycle pulse rewinding the command ROM to address 0.
REQ-009 rom_advance  out  1  one-cycle pulse stepping the ROM to the next entry.
REQ-010 rom_command  in  9  ROM word; bit8 = D/C (1 data, 0 command), bits7:0 = byte.
REQ-011 rom_finished  in  1  high when rom_command == 0x000 (NOP, end of table).
REQ-012 spi_valid/spi_ready  out/in  1/1  byte handshake to SPI serializer; transfer when both high.
REQ-013 spi_data  out  8  byte to send; spi_dc  out  1  D/C line for that byte.
REQ-014 pix_valid/pix_ready  in/out  1/1  pixel handshake; pix_data  in  18  {R6,G6,B6}.
REQ-015 init_done  out  1  level, high once table exhausted; frame_done  out  1  one-cycle pulse per completed frame; busy  out  1  high whenever not IDLE.

Function
REQ-016 States SHALL be IDLE, REWIND, SETTLE, FETCH, SEND, DELAY, STEP, PIX_WAIT, PIX_SEND, RAMWR.
REQ-017 IDLE + start -> REWIND: rom_resend high exactly one cycle -> SETTLE.
REQ-018 SETTLE SHALL count ROM_LAT cycles with rom_advance/rom_resend low, then -> FETCH.
REQ-019 FETCH: rom_finished -> PIX_WAIT with init_done set; else latch rom_command into byte register -> SEND.
REQ-020 SEND: spi_valid high, spi_data/spi_dc from latched word, stable until spi_ready; on transfer -> DELAY if latched word is 0x001 or 0x011 (D/C=0), else -> STEP.
REQ-021 DELAY: wait SWRESET_DLY or SLPOUT_DLY cycles respectively (counter 24 bits, loaded on entry, -> STEP at terminal count).
REQ-022 STEP: rom_advance high exactly one cycle -> SETTLE; consecutive advance pulses SHALL be separated by >= ROM_LAT+1 low cycles.
REQ-023 PIX_WAIT: pix_ready high; on pix_valid&pix_ready latch pix_data -> PIX_SEND; pix_ready SHALL be low in every other state.
REQ-024 PIX_SEND: three bytes, spi_dc=1, order {R,2'b00},{G,2'b00},{B,2'b00}, each held until spi_ready.
REQ-025 After third byte: pixel counter increments; if it was WIDTH*HEIGHT-1, counter -> 0, frame_done pulses same cycle, -> RAMWR; else -> PIX_WAIT.
REQ-026 RAMWR: send byte 0x2C with spi_dc=0 via handshake, then -> PIX_WAIT (first frame uses the table's own RAMWR).
REQ-027 start asserted outside IDLE SHALL be ignored; spi_ready while spi_valid low SHALL be ignored.
REQ-028 spi_valid SHALL never drop or change data before handshake completes.

Reset
REQ-029 rst_n low SHALL immediately force IDLE, all outputs 0, counters and latches 0, regardless of state (mid-byte, mid-delay, mid-frame).
REQ-030 After rst_n release, no output SHALL change until start observed.

Verification
REQ-031 SWRESET_DLY=10, SLPOUT_DLY=8, ROM model with table {0x001,0x011,0x0B1,0x100,0x02C,0x000}, spi_ready tied 1, start pulse -> bytes 01(dc0),11(dc0),B1(dc0),00(dc1),2C(dc0) in order; gap after 01 >= 10 cycles, after 11 >= 8; init_done rises after FETCH of 0x000.
REQ-032 spi_ready held low 5 cycles on byte B1 -> spi_valid, spi_data=0xB1, spi_dc=0 stable all 5 cycles, single transfer.
REQ-033 WIDTH=2, HEIGHT=2, after init, pix_data 0x3F000,0x00FC0,0x0003F,0x3FFFF -> bytes FC,00,00 / 00,FC,00 / 00,00,FC / FC,FC,FC (dc1), frame_done one pulse, then 2C (dc0), pixel counter 0.
REQ-034 pix_valid toggling randomly -> no pixel lost or duplicated; pix_ready low during PIX_SEND/RAMWR.
REQ-035 rst_n asserted mid-DELAY and mid-PIX_SEND -> all outputs 0 same cycle (async); new start replays table from address 0 with rom_resend pulse.
REQ-036 Checker: rom_advance never high two cycles within ROM_LAT+1, rom_resend single-cycle.
